fir_coeff_loader: RTL and testbench

Host-side driver for the adaptive FIR core's input port: it owns the sample stream (`x_n`, `tvalid`) and the in-band coefficient-load protocol (`set_coeffs` asserted for NUM_TAPS consecutive cycles, one coefficient per cycle on `x_n`, `tvalid` low). Samples arriving while a coefficient load is in progress are held in a small FIFO and replayed afterwards, so no input sample is dropped. The block sits between the chip input pins/registers and the FIR core.

---
 rtl/fir_pkg.sv | 25 ++
 rtl/fir_sample_fifo.sv | 94 +++++++++
 rtl/fir_coeff_loader.sv | 160 ++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR coefficient loader: default widths and depths,
// the loader state encoding and a helper that sizes the tap index register.
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_DATA_W     = 8;
  localparam int FIR_NUM_TAPS   = 3;
  localparam int FIR_FIFO_DEPTH = 4;

  // Loader states: STREAM forwards buffered samples, LOAD drives coefficients.
  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_LOAD   = 1'b1
  } fir_state_e;

  // Width of a counter that indexes n items (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FIR_TAP_IDX_W = idx_width(FIR_NUM_TAPS);

endpackage

// File: rtl/fir_sample_fifo.sv
// -----------------------------------------------------------------------------
// fir_sample_fifo
// Small synchronous FIFO that holds input samples while the loader is busy
// driving a coefficient sequence. DEPTH must be a power of two so the read and
// write pointers wrap naturally.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset (flushes the FIFO)
//   push_i         write push_data_i (ignored when full)
//   push_data_i    sample to store
//   pop_i          drop the head entry (ignored when empty)
//   head_o         current head entry, valid when !empty_o
//   full_o         count == DEPTH
//   empty_o        count == 0
//   count_o        number of stored entries
// -----------------------------------------------------------------------------
module fir_sample_fifo
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          push_data_i,
  input  logic                       pop_i,
  output logic [DATA_W-1:0]          head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              do_push_s, do_pop_s;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_q];
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  // Next pointer and occupancy values.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push_s) begin
      wr_d = wr_q + 1'b1;
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + 1'b1;
    end else begin
      rd_d = rd_q;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// fir_coeff_loader
// Drives the FIR core input port. In STREAM it forwards buffered samples one per
// cycle; on cfg_load it snapshots the coefficient vector and plays it out on
// fir_x_n with fir_set_coeffs high for NUM_TAPS cycles. Samples arriving during
// a load are buffered in fir_sample_fifo and forwarded afterwards.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   in_sample        incoming signed sample
//   in_valid         in_sample valid
//   in_ready         buffer has room; transfer when in_valid && in_ready
//   cfg_coeffs       coefficient k at bits [k*DATA_W +: DATA_W]
//   cfg_load         load request, honoured only in STREAM
//   cfg_busy         high while coefficients are being driven
//   cfg_done         one-cycle pulse after the last coefficient
//   fir_x_n          sample or coefficient to the FIR core
//   fir_tvalid       fir_x_n carries a sample
//   fir_set_coeffs   fir_x_n carries a coefficient
// -----------------------------------------------------------------------------
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int DATA_W     = FIR_DATA_W,
  parameter int NUM_TAPS   = FIR_NUM_TAPS,
  parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_sample,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_TAPS*DATA_W-1:0] cfg_coeffs,
  input  logic                       cfg_load,
  output logic                       cfg_busy,
  output logic                       cfg_done,
  output logic [DATA_W-1:0]          fir_x_n,
  output logic                       fir_tvalid,
  output logic                       fir_set_coeffs
);

  localparam int IDX_W = idx_width(NUM_TAPS);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  fir_state_e        state_q, state_d;
  logic [IDX_W-1:0]  tap_q, tap_d;
  logic [DATA_W-1:0] coeff_q [NUM_TAPS];
  logic [DATA_W-1:0] coeff_d [NUM_TAPS];
  logic [DATA_W-1:0] x_q, x_d;
  logic              tvalid_q, tvalid_d;
  logic              set_q, set_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              push_s, pop_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [DATA_W-1:0] fifo_head_s;
  logic [CNT_W-1:0]  fifo_count_s;

  assign in_ready = (fifo_count_s != FULL_CNT);
  assign push_s   = in_valid && !fifo_full_s;

  fir_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .push_data_i (in_sample),
    .pop_i       (pop_s),
    .head_o      (fifo_head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .count_o     (fifo_count_s)
  );

  // Next-state and output decode for the STREAM/LOAD controller.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    coeff_d  = coeff_q;
    x_d      = '0;
    tvalid_d = 1'b0;
    set_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    pop_s    = 1'b0;
    case (state_q)
      ST_STREAM: begin
        // set_q still high means this is the first STREAM cycle after a load:
        // that cycle reports completion and forwards no sample, so cfg_done
        // never coincides with fir_tvalid.
        done_d = set_q;
        if (cfg_load) begin
          for (int k = 0; k < NUM_TAPS; k++) begin
            coeff_d[k] = cfg_coeffs[k*DATA_W +: DATA_W];
          end
          tap_d   = '0;
          state_d = ST_LOAD;
        end else if (!set_q && !fifo_empty_s) begin
          pop_s    = 1'b1;
          x_d      = fifo_head_s;
          tvalid_d = 1'b1;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_LOAD: begin
        set_d  = 1'b1;
        busy_d = 1'b1;
        x_d    = coeff_q[tap_q];
        if (tap_q == LAST_TAP) begin
          tap_d   = '0;
          state_d = ST_STREAM;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
      default: begin
        tap_d   = '0;
        state_d = ST_STREAM;
      end
    endcase
  end

  // Controller state, coefficient snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_STREAM;
      tap_q    <= '0;
      x_q      <= '0;
      tvalid_q <= 1'b0;
      set_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        coeff_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      x_q      <= x_d;
      tvalid_q <= tvalid_d;
      set_q    <= set_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      coeff_q  <= coeff_d;
    end
  end

  assign fir_x_n        = x_q;
  assign fir_tvalid     = tvalid_q;
  assign fir_set_coeffs = set_q;
  assign cfg_busy       = busy_q;
  assign cfg_done       = done_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_fir_coeff_loader
// Directed checks of reset, latency, load sequencing, backpressure and reset
// during a load, followed by randomized traffic checked by a scoreboard: the
// stimulus side predicts the accepted samples (in order), the cycle of every
// coefficient beat and every cfg_done pulse; a negedge monitor compares.
// -----------------------------------------------------------------------------
module tb_fir_coeff_loader;

  localparam int DW = 8;
  localparam int NT = 3;
  localparam int FD = 4;
  localparam int CW = NT * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_sample;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] cfg_coeffs;
  logic          cfg_load;
  logic          cfg_busy;
  logic          cfg_done;
  logic [DW-1:0] fir_x_n;
  logic          fir_tvalid;
  logic          fir_set_coeffs;

  fir_coeff_loader #(
    .DATA_W     (DW),
    .NUM_TAPS   (NT),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_sample      (in_sample),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cfg_coeffs     (cfg_coeffs),
    .cfg_load       (cfg_load),
    .cfg_busy       (cfg_busy),
    .cfg_done       (cfg_done),
    .fir_x_n        (fir_x_n),
    .fir_tvalid     (fir_tvalid),
    .fir_set_coeffs (fir_set_coeffs)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int unsigned edge_cnt = 0;
  bit          mon_en = 1'b0;
  int          blk = 0;  // upcoming edges at which cfg_load is ignored

  typedef struct {
    int unsigned   at_edge;
    logic [DW-1:0] val;
  } sched_t;

  sched_t        exp_set[$];
  int unsigned   exp_done[$];
  logic [DW-1:0] exp_smp[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard monitor: outputs sampled mid-cycle after each active edge.
  bit m_set, m_done;
  always @(negedge clk) begin
    if (mon_en) begin
      m_set  = (exp_set.size() > 0) && (exp_set[0].at_edge == edge_cnt);
      m_done = (exp_done.size() > 0) && (exp_done[0] == edge_cnt);
      chk("sb_set_coeffs", fir_set_coeffs, m_set);
      chk("sb_busy", cfg_busy, m_set);
      chk("sb_done", cfg_done, m_done);
      if (m_set) begin
        chk("sb_coeff", fir_x_n, exp_set[0].val);
        void'(exp_set.pop_front());
      end
      if (m_done) void'(exp_done.pop_front());
      if (m_set || m_done) begin
        chk("sb_tvalid_excl", fir_tvalid, 0);
      end else if (fir_tvalid) begin
        if (exp_smp.size() == 0) chk("sb_unexpected_sample", fir_tvalid, 0);
        else chk("sb_sample", fir_x_n, exp_smp.pop_front());
      end else begin
        chk("sb_idle_x", fir_x_n, 0);
      end
    end
  end

  // One stimulus cycle: drive inputs, predict the DUT's response, wait one edge.
  task automatic cyc(input bit v, input logic [DW-1:0] s, input bit ld,
                     input logic [CW-1:0] co, output bit acc);
    in_valid   = v;
    in_sample  = s;
    cfg_load   = ld;
    cfg_coeffs = co;
    acc = v && in_ready;
    if (acc) exp_smp.push_back(s);
    if (blk > 0) begin
      blk--;
    end else if (ld) begin
      // Accepted at edge E = edge_cnt+1: coefficients at E+1..E+NT, done at E+NT+1.
      for (int k = 0; k < NT; k++) begin
        sched_t e;
        e.at_edge = edge_cnt + 2 + k;
        e.val     = co[k*DW +: DW];
        exp_set.push_back(e);
      end
      exp_done.push_back(edge_cnt + 2 + NT);
      blk = NT;
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] s, input bit ld, input logic [CW-1:0] co);
    bit acc = 1'b0;
    bit l   = ld;
    int tries = 0;
    while (!acc && tries < 40) begin
      cyc(1'b1, s, l, co, acc);
      l = 1'b0;
      tries++;
    end
    if (!acc) chk("send_timeout_in_ready", in_ready, 1);
  endtask

  logic [DW-1:0] got[$];
  int            n_acc;
  logic [DW-1:0] nxt;
  bit            a, seen_v, seen_d, pend, rv, acc_r;
  logic [DW-1:0] ps;
  int            w;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; cfg_load = 1'b0; cfg_coeffs = '0;
    @(negedge clk);
    tick(); tick();
    chk("rst_x_n", fir_x_n, 0);
    chk("rst_tvalid", fir_tvalid, 0);
    chk("rst_set", fir_set_coeffs, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Stream 0,1,0: each appears one cycle after acceptance.
    in_valid = 1'b1; in_sample = 8'd0; tick();
    chk("lat_first_idle", fir_tvalid, 0);
    in_sample = 8'd1; tick();
    chk("s0_x", fir_x_n, 0); chk("s0_v", fir_tvalid, 1);
    in_sample = 8'd0; tick();
    chk("s1_x", fir_x_n, 1); chk("s1_v", fir_tvalid, 1);
    in_valid = 1'b0; tick();
    chk("s2_x", fir_x_n, 0); chk("s2_v", fir_tvalid, 1);
    tick();
    chk("empty_v", fir_tvalid, 0);

    // Load {3,2,1}; cfg_load held through LOAD must be ignored.
    cfg_coeffs = {8'd3, 8'd2, 8'd1}; cfg_load = 1'b1; tick();
    chk("ld_launch_set", fir_set_coeffs, 0);
    cfg_coeffs = 24'hAABBCC;
    for (int k = 0; k < NT; k++) begin
      tick();
      chk("ld_set", fir_set_coeffs, 1);
      chk("ld_busy", cfg_busy, 1);
      chk("ld_coeff", fir_x_n, k + 1);
      chk("ld_tvalid", fir_tvalid, 0);
      chk("ld_done_early", cfg_done, 0);
    end
    cfg_load = 1'b0; tick();
    chk("ld_end_set", fir_set_coeffs, 0);
    chk("ld_end_busy", cfg_busy, 0);
    chk("ld_end_done", cfg_done, 1);
    chk("ld_end_tvalid", fir_tvalid, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ld_no_extra_set", fir_set_coeffs, 0);
      chk("ld_single_done", cfg_done, 0);
    end

    // Backpressure: in_valid held across a load.
    cfg_coeffs = 24'h123456; cfg_load = 1'b1; in_valid = 1'b1;
    nxt = 8'd20; in_sample = nxt; n_acc = 0; got.delete();
    for (int c = 0; c < 18; c++) begin
      a = in_valid && in_ready;
      tick();
      cfg_load = 1'b0;
      if (a) begin n_acc++; nxt = nxt + 8'd1; end
      if (fir_tvalid) got.push_back(fir_x_n);
      if (c == 3 || c == 4) chk("bp_full", in_ready, 0);
      if (c == 4) begin
        chk("bp_done", cfg_done, 1);
        chk("bp_done_tvalid", fir_tvalid, 0);
      end
      if (c == 5) chk("bp_resume", in_ready, 1);
      in_valid  = (n_acc < 10);
      in_sample = nxt;
    end
    chk("bp_count", got.size(), 10);
    for (int i = 0; i < got.size(); i++) chk("bp_order", got[i], 20 + i);

    // Reset after coeff1 of a load, with two samples buffered.
    cfg_coeffs = {8'd9, 8'd8, 8'd7}; cfg_load = 1'b1; in_valid = 1'b1; in_sample = 8'd50; tick();
    cfg_load = 1'b0; in_sample = 8'd51; tick();
    chk("rml_c0", fir_x_n, 7);
    in_valid = 1'b0; tick();
    chk("rml_c1", fir_x_n, 8);
    rst_n = 1'b0; tick();
    chk("rml_set", fir_set_coeffs, 0);
    chk("rml_busy", cfg_busy, 0);
    chk("rml_x", fir_x_n, 0);
    chk("rml_tvalid", fir_tvalid, 0);
    rst_n = 1'b1; seen_v = 1'b0; seen_d = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      seen_v |= fir_tvalid;
      seen_d |= cfg_done;
    end
    chk("rml_fifo_flushed", seen_v, 0);
    chk("rml_no_done", seen_d, 0);
    chk("rml_in_ready", in_ready, 1);

    // Scoreboard phase.
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
    blk = 0; exp_set.delete(); exp_done.delete(); exp_smp.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(10 + i), (i == 3), CW'($urandom));
    pend = 1'b0; rv = 1'b0; ps = '0;
    for (int i = 0; i < 600; i++) begin
      if (!pend) begin
        rv = (i < 300) ? ($urandom_range(0, 9) < 5) : ($urandom_range(0, 19) != 0);
        ps = DW'($urandom);
      end
      cyc(rv, ps, ($urandom_range(0, 99) < ((i < 300) ? 5 : 12)), CW'($urandom), acc_r);
      pend = rv && !acc_r;
    end
    w = 0;
    while ((exp_smp.size() + exp_set.size() + exp_done.size()) != 0 && w < 80) begin
      cyc(1'b0, '0, 1'b0, '0, acc_r);
      w++;
    end
    chk("drain_outstanding", exp_smp.size() + exp_set.size() + exp_done.size(), 0);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
